// File: rtl/fifo_stream_packetizer.sv
// Drains a show-ahead FIFO into stream packets: header word, up to BURST_LEN payload words, tlast on the final word.
// Define FIFO_PKT_CHECKSUM_EN to append an XOR trailer word; the trailer then carries tlast.
module fifo_stream_packetizer #(
  parameter int DATA_WIDTH     = 32,
  parameter int FILL_WIDTH     = 11,
  parameter int BURST_LEN      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic                  i_fifo_valid,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic [FILL_WIDTH-1:0] i_fifo_fill,
  output logic                  o_fifo_rd_en,
  output logic                  o_m_tvalid,
  input  logic                  i_m_tready,
  output logic [DATA_WIDTH-1:0] o_m_tdata,
  output logic                  o_m_tlast,
  output logic                  o_busy,
  output logic [7:0]            o_seq
);

  // state     | meaning
  // S_IDLE    | waiting for a full burst or a partial-fill timeout
  // S_HEADER  | header waiting for an output buffer slot
  // S_PAYLOAD | popping len words into the output buffer
  // S_TRAILER | XOR checksum word waiting for a slot (checksum build only)
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2
`ifdef FIFO_PKT_CHECKSUM_EN
    , S_TRAILER = 2'd3
`endif
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]         TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FILL_WIDTH-1:0] BURST_FILL = FILL_WIDTH'(BURST_LEN);
  localparam logic [15:0]           BURST_16   = 16'(BURST_LEN);

  state_t                state_q, state_d;
  logic [7:0]            seq_q;
  logic [15:0]           rem_q;
  logic [TW-1:0]         to_cnt_q;
  logic                  v0_q, v1_q, l0_q, l1_q;
  logic [DATA_WIDTH-1:0] d0_q, d1_q;
`ifdef FIFO_PKT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] acc_q;
`endif

  logic                  start, hdr_wr, pop, push, push_last, accept, space;
  logic                  full_ready;
  logic [DATA_WIDTH-1:0] push_data, hdr_word;

  assign full_ready = i_fifo_fill >= BURST_FILL;
  assign hdr_word   = DATA_WIDTH'({8'hA5, seq_q, rem_q});
  // Space is judged from registered occupancy only, so tready never reaches the pop path.
  assign space      = !v1_q;
  assign accept     = v0_q && i_m_tready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    hdr_wr    = 1'b0;
    pop       = 1'b0;
    push      = 1'b0;
    push_last = 1'b0;
    push_data = '0;
    case (state_q)
      S_IDLE: begin
        if (i_enable && (full_ready || (i_fifo_fill != '0 && to_cnt_q == TO_LAST))) begin
          start   = 1'b1;
          state_d = S_HEADER;
        end
      end
      S_HEADER: begin
        if (space) begin
          push      = 1'b1;
          hdr_wr    = 1'b1;
          push_data = hdr_word;
          state_d   = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (i_fifo_valid && rem_q != 16'd0 && space) begin
          pop       = 1'b1;
          push      = 1'b1;
          push_data = i_fifo_data;
`ifdef FIFO_PKT_CHECKSUM_EN
          push_last = 1'b0;
          if (rem_q == 16'd1) state_d = S_TRAILER;
`else
          push_last = (rem_q == 16'd1);
          if (rem_q == 16'd1) state_d = S_IDLE;
`endif
        end
      end
`ifdef FIFO_PKT_CHECKSUM_EN
      S_TRAILER: begin
        if (space) begin
          push      = 1'b1;
          push_last = 1'b1;
          push_data = acc_q ^ '0;
          state_d   = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q    <= '0;
      rem_q    <= '0;
      to_cnt_q <= '0;
    end else begin
      if (hdr_wr) seq_q <= seq_q + 8'd1;
      if (start) rem_q <= full_ready ? BURST_16 : 16'(i_fifo_fill);
      else if (pop) rem_q <= rem_q - 16'd1;
      if (state_q != S_IDLE || start || !i_enable || i_fifo_fill == '0)
        to_cnt_q <= '0;
      else if (!full_ready && to_cnt_q != TO_LAST)
        to_cnt_q <= to_cnt_q + TW'(1);
    end
  end

`ifdef FIFO_PKT_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)         acc_q <= '0;
    else if (hdr_wr) acc_q <= '0;
    else if (pop)    acc_q <= acc_q ^ i_fifo_data;
  end
`endif

  // Two-entry output buffer; entry 0 is always the word presented downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      l0_q <= 1'b0;
      l1_q <= 1'b0;
      d0_q <= '0;
      d1_q <= '0;
    end else if (accept && !push) begin
      v0_q <= v1_q;
      d0_q <= d1_q;
      l0_q <= l1_q;
      v1_q <= 1'b0;
    end else if (push && (accept || !v0_q)) begin
      v0_q <= 1'b1;
      d0_q <= push_data;
      l0_q <= push_last;
    end else if (push) begin
      v1_q <= 1'b1;
      d1_q <= push_data;
      l1_q <= push_last;
    end
  end

  assign o_fifo_rd_en = pop && !rst;
  assign o_m_tvalid   = v0_q;
  assign o_m_tdata    = d0_q;
  assign o_m_tlast    = l0_q;
  assign o_busy       = (state_q != S_IDLE) || v0_q;
  assign o_seq        = seq_q;

endmodule

// File: tb/tb_fifo_stream_packetizer.sv
// Self-checking bench for fifo_stream_packetizer: queue-based FIFO, packet scoreboard, vector table, corner sequences.
module tb_fifo_stream_packetizer;
  localparam int DW = 32;
  localparam int FW = 11;
  localparam int BL = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_enable = 1'b0;
  logic          fifo_valid = 1'b0;
  logic [DW-1:0] fifo_data = '0;
  logic [FW-1:0] fifo_fill = '0;
  logic          tready = 1'b0;
  logic          rd_en, tvalid, tlast, busy;
  logic [DW-1:0] tdata;
  logic [7:0]    seq;

  always #5 clk = ~clk;

  fifo_stream_packetizer #(
    .DATA_WIDTH(DW), .FILL_WIDTH(FW), .BURST_LEN(BL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable),
    .i_fifo_valid(fifo_valid), .i_fifo_data(fifo_data), .i_fifo_fill(fifo_fill),
    .o_fifo_rd_en(rd_en), .o_m_tvalid(tvalid), .i_m_tready(tready),
    .o_m_tdata(tdata), .o_m_tlast(tlast), .o_busy(busy), .o_seq(seq)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] log_data[$];
  logic          log_last[$];
  int            log_cyc[$];

  int tr_mode = 0;
  int hold_cnt = 0;
  int hold_target = -1;
  int pops_total = 0;
  int acc_pay = 0;
  int drop_at = 0;

  int            sb_rem = 0;
  bit            sb_trl = 1'b0;
  logic [DW-1:0] sb_xor = '0;
  logic [7:0]    exp_seq = 8'd0;
  int            pkt_count = 0;
  int            last_len = 0;
  int            last_hdr_seq = 0;

  logic          s_rst, s_rd, s_tv, s_tl, s_busy, s_fv;
  logic [DW-1:0] s_td;
  logic [7:0]    s_seq;
  logic          prev_stall = 1'b0;
  logic          prev_last = 1'b0;
  logic [DW-1:0] prev_data = '0;

  typedef struct {
    int n_words;
    int mode;
    int exp_pkts;
    int exp_last_len;
  } row_t;
  row_t rows[6];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic drive_fifo();
    if (hold_cnt > 0) begin
      fifo_valid = 1'b0;
      fifo_fill  = '0;
      fifo_data  = '0;
    end else begin
      fifo_valid = (fq.size() != 0);
      fifo_fill  = FW'(fq.size());
      fifo_data  = (fq.size() != 0) ? fq[0] : '0;
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  // Packet-level reference: header fields, then the next len FIFO words in order, tlast on the final word.
  task automatic sb_accept(input logic [DW-1:0] d, input logic l);
    logic [DW-1:0] e;
    int len;
    log_data.push_back(d);
    log_last.push_back(l);
    log_cyc.push_back(cyc);
    if (sb_rem == 0 && !sb_trl) begin
      len = int'(d[15:0]);
      chk("hdr_tag", d[31:24], 8'hA5);
      chk("hdr_seq", d[23:16], exp_seq);
      chk("hdr_len_range", (len >= 1 && len <= BL), 1);
      chk("hdr_tlast", l, 0);
      last_hdr_seq = int'(d[23:16]);
      exp_seq++;
      pkt_count++;
      last_len = len;
      sb_rem = len;
      sb_xor = '0;
    end else if (sb_rem > 0) begin
      if (exp_q.size() == 0) fail_now("payload_unexpected_word");
      else begin
        e = exp_q.pop_front();
        chk("payload_data", d, e);
      end
      sb_xor ^= d;
      acc_pay++;
      sb_rem--;
`ifdef FIFO_PKT_CHECKSUM_EN
      chk("payload_tlast", l, 0);
      if (sb_rem == 0) sb_trl = 1'b1;
`else
      chk("payload_tlast", l, (sb_rem == 0));
`endif
    end else begin
      chk("trailer_data", d, sb_xor);
      chk("trailer_tlast", l, 1);
      sb_trl = 1'b0;
    end
  endtask

  task automatic tick();
    logic [DW-1:0] junk;
    @(negedge clk);
    cyc++;
    s_rst = rst; s_rd = rd_en; s_tv = tvalid; s_td = tdata; s_tl = tlast;
    s_busy = busy; s_seq = seq; s_fv = fifo_valid;
    if (prev_stall) begin
      chk("stall_tvalid", s_tv, 1);
      chk("stall_tdata", s_td, prev_data);
      chk("stall_tlast", s_tl, prev_last);
    end
    if (s_rd) chk("pop_only_nonempty", s_fv, 1);
    if (s_tv) chk("outstanding_le2", (pops_total - acc_pay <= 2), 1);
    prev_stall = s_tv && !tready;
    prev_data  = s_td;
    prev_last  = s_tl;
    if (s_tv && tready) sb_accept(s_td, s_tl);
    @(posedge clk);
    #1;
    if (s_rst) begin
      fq.delete(); exp_q.delete();
      sb_rem = 0; sb_trl = 1'b0; exp_seq = 8'd0;
      pops_total = 0; acc_pay = 0; prev_stall = 1'b0;
      hold_cnt = 0; hold_target = -1;
    end else if (s_rd && fq.size() != 0) begin
      junk = fq.pop_front();
      pops_total++;
    end
    if (hold_cnt > 0) hold_cnt--;
    if (hold_target >= 0 && pops_total == hold_target) begin
      hold_cnt = 10;
      hold_target = -1;
    end
    case (tr_mode)
      0:       tready = 1'b1;
      1:       tready = ~tready;
      default: tready = 1'($urandom_range(0, 1));
    endcase
    if (drop_at > 0 && pkt_count >= drop_at) i_enable = 1'b0;
    drive_fifo();
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(s_busy == 1'b0 && fq.size() == 0 && sb_rem == 0 && !sb_trl) && n < budget);
    if (n >= budget) fail_now({name, "_timeout"});
  endtask

  initial begin
    int t_push, p0, nl, n;
    logic [DW-1:0] bexp[6];

    rows[0] = '{4, 1, 1, 4};
    rows[1] = '{6, 1, 2, 2};
    rows[2] = '{3, 2, 1, 3};
    rows[3] = '{9, 2, 3, 1};
    rows[4] = '{8, 0, 2, 4};
    rows[5] = '{5, 2, 2, 1};

    drive_fifo();
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_tvalid", s_tv, 0);
    chk("rst_rd_en", s_rd, 0);
    chk("rst_seq", s_seq, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_tlast", s_tl, 0);
    chk("rst_tdata", s_td, 0);

    // Full burst, back-to-back output.
    i_enable = 1'b1;
    tr_mode = 0;
    log_data.delete(); log_last.delete(); log_cyc.delete();
    for (int i = 0; i < 4; i++) push_word(DW'(32'h11 + i));
    drive_fifo();
    wait_idle(100, "burst");
    bexp[0] = 32'hA500_0004; bexp[1] = 32'h11; bexp[2] = 32'h12;
    bexp[3] = 32'h13; bexp[4] = 32'h14; bexp[5] = 32'h04;
`ifdef FIFO_PKT_CHECKSUM_EN
    n = 6;
`else
    n = 5;
`endif
    chk("burst_words", log_data.size(), n);
    if (log_data.size() == n) begin
      for (int i = 0; i < n; i++) begin
        chk("burst_data", log_data[i], bexp[i]);
        chk("burst_tlast", log_last[i], (i == n - 1));
      end
      chk("burst_back_to_back", log_cyc[n-1] - log_cyc[0], n - 1);
    end
    chk("burst_seq_after", s_seq, 1);

    // Partial fill flushed by timeout.
    log_data.delete(); log_last.delete(); log_cyc.delete();
    push_word(32'hAA); push_word(32'hBB);
    drive_fifo();
    t_push = cyc + 1;
    wait_idle(100, "timeout");
`ifdef FIFO_PKT_CHECKSUM_EN
    n = 4;
`else
    n = 3;
`endif
    chk("to_words", log_data.size(), n);
    if (log_data.size() == n) begin
      chk("to_header", log_data[0], 32'hA501_0002);
      chk("to_header_delay", log_cyc[0] - t_push, 9);
      chk("to_data_bb", log_data[2], 32'hBB);
      chk("to_bb_tlast", log_last[2], (n == 3));
      chk("to_final_tlast", log_last[n-1], 1);
      chk("to_final_data", log_data[n-1], (n == 3) ? 32'hBB : 32'h11);
    end

    // Vector table: preload, tready pattern, expected packet count and last length.
    for (int r = 0; r < 6; r++) begin
      tr_mode = rows[r].mode;
      p0 = pkt_count;
      for (int i = 0; i < rows[r].n_words; i++) push_word($urandom);
      drive_fifo();
      wait_idle(600, "row");
      chk("row_pkts", pkt_count - p0, rows[r].exp_pkts);
      chk("row_last_len", last_len, rows[r].exp_last_len);
    end

    // FIFO starves after two pops and is refilled ten cycles later.
    tr_mode = 0;
    p0 = pkt_count;
    log_data.delete(); log_last.delete(); log_cyc.delete();
    hold_target = pops_total + 2;
    for (int i = 0; i < 4; i++) push_word($urandom);
    drive_fifo();
    wait_idle(200, "starve");
    chk("starve_pkts", pkt_count - p0, 1);
    chk("starve_len", last_len, 4);
    nl = 0;
    foreach (log_last[i]) if (log_last[i]) nl++;
    chk("starve_one_tlast", nl, 1);
    if (log_cyc.size() > 1) chk("starve_gap_seen", (log_cyc[log_cyc.size()-1] - log_cyc[0] >= 10), 1);
    else fail_now("starve_no_output");

    // Reset during a payload word.
    tr_mode = 0;
    for (int i = 0; i < 4; i++) push_word($urandom);
    drive_fifo();
    n = 0;
    while (pops_total < 2 && n < 100) begin tick(); n++; end
    if (n >= 100) fail_now("rstmid_wait_timeout");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rstmid_tvalid", s_tv, 0);
    chk("rstmid_rd_en", s_rd, 0);
    chk("rstmid_seq", s_seq, 0);
    log_data.delete(); log_last.delete(); log_cyc.delete();
    for (int i = 0; i < 4; i++) push_word($urandom);
    drive_fifo();
    wait_idle(100, "rstmid_next");
    if (log_data.size() > 0) chk("rstmid_next_header", log_data[0], 32'hA500_0004);
    else fail_now("rstmid_no_output");

    // Sequence wrap over 257 packets with random backpressure, then enable drops during the last.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tr_mode = 2;
    for (int i = 0; i < 258 * 4; i++) push_word($urandom);
    drive_fifo();
    pkt_count = 0;
    drop_at = 257;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(pkt_count >= 257 && !s_busy && sb_rem == 0 && !sb_trl) && n < 20000);
    if (n >= 20000) fail_now("wrap_timeout");
    for (int i = 0; i < 40; i++) tick();
    chk("wrap_pkts", pkt_count, 257);
    chk("wrap_last_seq", last_hdr_seq, 0);
    chk("wrap_o_seq", s_seq, 1);
    chk("wrap_fifo_left", fq.size(), 4);
    chk("wrap_idle", s_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
